// File: rtl/ftsd_pkg.sv
// Shared definitions for the multiplexed 14-segment display scan blocks.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package ftsd_pkg;

    localparam logic FTSD_OFF = 1'b1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_st_e;

    // Never returns 0, so a 1-deep counter still gets a real bit.
    function automatic int clog2_safe(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ftsd_prescaler.sv
// Free-running slot prescaler: counts 0..DIV-1 and wraps, with terminal-count and slot-start flags.
// Latency: flags decode the current count combinationally; the count itself is registered.
// Backpressure: none; the counter runs every cycle.
module ftsd_prescaler
    import ftsd_pkg::*;
#(
    parameter  int DIV = 1024,
    localparam int W   = clog2_safe(DIV)
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         slot_start
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign tc         = (cnt_q == LAST);
    assign slot_start = (cnt_q == '0);

endmodule

// File: rtl/ftsd_scan_ctl_n.sv
// Self-timed N-digit scan controller with inter-digit blanking, per-digit enable and blink.
// Latency: every output is registered, one cycle behind the prescaler/state condition.
// Backpressure: none; inputs are sampled once per slot on entry to SHOW.
module ftsd_scan_ctl_n
    import ftsd_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int SCAN_DIV     = 1024,
    parameter  int BLANK_CYCLES = 16,
    parameter  int BLINK_FRAMES = 64,
    localparam int IW           = clog2_safe(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   ftsd_ctl,
    output logic [3:0]              ftsd_in,
    output logic [IW-1:0]           scan_idx,
    output logic                    frame_start
);

    localparam int PW = clog2_safe(SCAN_DIV);
    localparam int FW = clog2_safe(BLINK_FRAMES + 1);

    localparam logic [NUM_DIGITS-1:0] CTL_OFF    = {NUM_DIGITS{FTSD_OFF}};
    localparam logic [IW-1:0]         LAST_SLOT  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         BLINK_TERM = FW'(BLINK_FRAMES);

    logic [PW-1:0] presc;
    logic          presc_tc;
    logic          presc_start;
    logic          in_blank;

    ftsd_prescaler #(.DIV(SCAN_DIV)) u_presc (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt        (presc),
        .tc         (presc_tc),
        .slot_start (presc_start)
    );

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (presc < PW'(BLANK_CYCLES));
        end
    endgenerate

    scan_st_e              state_q, state_d;
    logic [IW-1:0]         slot_q, slot_d;
    logic [FW-1:0]         frm_q, frm_d;
    logic                  blink_on_q, blink_on_d;
    logic [NUM_DIGITS-1:0] ctl_q, ctl_d;
    logic [3:0]            val_q, val_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  fs_q, fs_d;

    logic          frame_wrap;
    logic          entry;
    logic          lit;
    logic [IW-1:0] sel_bit;

    always_comb begin
        state_d    = in_blank ? ST_BLANK : ST_SHOW;
        frame_wrap = presc_tc && (slot_q == LAST_SLOT);
        slot_d     = slot_q;
        frm_d      = frm_q;
        blink_on_d = blink_on_q;

        if (presc_tc) begin
            slot_d = frame_wrap ? '0 : slot_q + 1'b1;
        end
        if (frame_wrap) begin
            if (frm_q + 1'b1 == BLINK_TERM) begin
                frm_d      = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end

        // With no blanking every cycle is SHOW, so slot start doubles as the entry point.
        entry   = (state_d == ST_SHOW) && ((state_q == ST_BLANK) || presc_start);
        lit     = digit_en[slot_q] & ~(blink_mask[slot_q] & ~blink_on_q);
        sel_bit = LAST_SLOT - slot_q;

        ctl_d = CTL_OFF;
        if (state_d == ST_SHOW) begin
            if (entry) begin
                if (lit) begin
                    ctl_d[sel_bit] = ~FTSD_OFF;
                end
            end else begin
                ctl_d = ctl_q;
            end
        end

        val_d = entry ? digits_in[{slot_q, 2'b00} +: 4] : val_q;
        idx_d = slot_q;
        fs_d  = presc_start && (slot_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            slot_q     <= '0;
            frm_q      <= '0;
            blink_on_q <= 1'b1;
            ctl_q      <= CTL_OFF;
            val_q      <= '0;
            idx_q      <= '0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            frm_q      <= frm_d;
            blink_on_q <= blink_on_d;
            ctl_q      <= ctl_d;
            val_q      <= val_d;
            idx_q      <= idx_d;
            fs_q       <= fs_d;
        end
    end

    assign ftsd_ctl    = ctl_q;
    assign ftsd_in     = val_q;
    assign scan_idx    = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ftsd_scan_ctl_n.sv
// Scoreboard bench for ftsd_scan_ctl_n: per-slot expected records queued by stimulus, checked by a monitor.
// A second N=8, no-blanking instance is checked every cycle for the one-digit-on invariant.
module tb_ftsd_scan_ctl_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic [3:0]  blink_mask;
    logic [3:0]  ftsd_ctl;
    logic [3:0]  ftsd_in;
    logic [1:0]  scan_idx;
    logic        frame_start;

    logic        rst8_n;
    logic [31:0] digits8;
    logic [7:0]  en8;
    logic [7:0]  mask8;
    logic [7:0]  ctl8;
    logic [3:0]  in8;
    logic [2:0]  idx8;
    logic        fs8;

    ftsd_scan_ctl_n #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .digit_en(digit_en),
        .blink_mask(blink_mask), .ftsd_ctl(ftsd_ctl), .ftsd_in(ftsd_in),
        .scan_idx(scan_idx), .frame_start(frame_start)
    );

    ftsd_scan_ctl_n #(
        .NUM_DIGITS(8), .SCAN_DIV(8), .BLANK_CYCLES(0), .BLINK_FRAMES(2)
    ) dut8 (
        .clk(clk), .rst_n(rst8_n), .digits_in(digits8), .digit_en(en8),
        .blink_mask(mask8), .ftsd_ctl(ctl8), .ftsd_in(in8),
        .scan_idx(idx8), .frame_start(fs8)
    );

    typedef struct packed {
        logic [3:0] ctl;
        logic [3:0] val;
        logic [1:0] idx;
        logic       fs;
    } slot_t;

    slot_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    k      = -1;
    int    k8     = -1;
    bit    in_rst = 1'b0;
    int    wraps8 = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            k      <= 0;
            in_rst <= 1'b1;
        end else begin
            in_rst <= 1'b0;
            if (k >= 0) k <= k + 1;
        end
        if (!rst8_n) k8 <= 0;
        else if (k8 >= 0) k8 <= k8 + 1;
    end

    slot_t      cur;
    bit         cur_ok = 1'b0;
    int         pos;
    int         jj;
    logic [3:0] exp_ctl;
    logic       exp_fs;

    always @(negedge clk) begin
        if (in_rst) begin
            n_chk++;
            if (ftsd_ctl !== 4'hF || ftsd_in !== 4'h0 || scan_idx !== 2'd0 || frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_vals: ctl=%b in=%h idx=%0d fs=%b, want ctl=1111 in=0 idx=0 fs=0",
                         ftsd_ctl, ftsd_in, scan_idx, frame_start);
            end
        end else if (k >= 1) begin
            pos = k - 1;
            jj  = pos % 8;
            if (jj == 0) begin
                if (sb.size() == 0) begin
                    cur_ok = 1'b0;
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: slot at pos %0d has no expected record", pos);
                end else begin
                    cur    = sb.pop_front();
                    cur_ok = 1'b1;
                end
            end
            if (cur_ok) begin
                exp_ctl = (jj < 2) ? 4'hF : cur.ctl;
                exp_fs  = (jj == 0) ? cur.fs : 1'b0;
                n_chk++;
                if (ftsd_ctl !== exp_ctl || scan_idx !== cur.idx || frame_start !== exp_fs ||
                    (jj >= 2 && ftsd_in !== cur.val)) begin
                    n_fail++;
                    $display("FAIL slot pos=%0d j=%0d: ctl=%b in=%h idx=%0d fs=%b, want ctl=%b in=%h idx=%0d fs=%b",
                             pos, jj, ftsd_ctl, ftsd_in, scan_idx, frame_start,
                             exp_ctl, cur.val, cur.idx, exp_fs);
                end
            end
        end
    end

    int         e8;
    logic [7:0] exp8;
    logic [2:0] prev_idx8 = 3'd0;

    always @(negedge clk) begin
        if (k8 >= 1) begin
            e8   = ((k8 - 1) / 8) % 8;
            exp8 = ~(8'b1 << (7 - e8));
            n_chk++;
            assert ($onehot(~ctl8) && ctl8 === exp8 && idx8 === 3'(e8) && in8 === 4'(e8))
            else begin
                n_fail++;
                $display("FAIL n8_select pos=%0d: ctl=%b in=%h idx=%0d, want ctl=%b in=%h idx=%0d",
                         k8 - 1, ctl8, in8, idx8, exp8, 4'(e8), e8);
            end
            if (prev_idx8 == 3'd7 && idx8 == 3'd0) wraps8++;
            prev_idx8 = idx8;
        end
    end

    task automatic push(input logic [3:0] c, input logic [3:0] v, input logic [1:0] i, input logic f);
        slot_t s;
        s.ctl = c;
        s.val = v;
        s.idx = i;
        s.fs  = f;
        sb.push_back(s);
    endtask

    task automatic push_frame(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                              input logic [3:0] c3, input logic [15:0] d);
        push(c0, d[3:0],   2'd0, 1'b1);
        push(c1, d[7:4],   2'd1, 1'b0);
        push(c2, d[11:8],  2'd2, 1'b0);
        push(c3, d[15:12], 2'd3, 1'b0);
    endtask

    task automatic wait_k(input int t);
        int guard;
        guard = 0;
        while (k < t && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_timeout: k=%0d, want %0d", k, t);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        digits_in  = 16'h4321;
        digit_en   = 4'hF;
        blink_mask = 4'h0;
        rst8_n     = 1'b0;
        digits8    = 32'h7654_3210;
        en8        = 8'hFF;
        mask8      = 8'h00;

        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4321);
        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4321);
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst8_n = 1'b1;

        wait_k(64);
        digit_en = 4'b1010;
        push_frame(4'b1111, 4'b1011, 4'b1111, 4'b1110, 16'h4321);
        push_frame(4'b1111, 4'b1011, 4'b1111, 4'b1110, 16'h4321);

        wait_k(128);
        digit_en = 4'hF;
        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4321);
        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4321);

        // Slot 0 presc=4: already latched, so the new digit 0 shows up one frame later.
        wait_k(164);
        digits_in = 16'h4329;
        push(4'b0111, 4'h9, 2'd0, 1'b1);
        push(4'b1011, 4'h2, 2'd1, 1'b0);
        push(4'b1101, 4'h3, 2'd2, 1'b0);

        wait_k(213);
        rst_n      = 1'b0;
        blink_mask = 4'b0001;
        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4329);
        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4329);
        push_frame(4'b1111, 4'b1011, 4'b1101, 4'b1110, 16'h4329);
        push_frame(4'b1111, 4'b1011, 4'b1101, 4'b1110, 16'h4329);
        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4329);
        push_frame(4'b0111, 4'b1011, 4'b1101, 4'b1110, 16'h4329);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        wait_k(193);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d records left, want 0", sb.size());
        end
        n_chk++;
        if (wraps8 < 5) begin
            n_fail++;
            $display("FAIL n8_wrap: saw %0d 7->0 wraps, want at least 5", wraps8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
